spi_slave_word_rx: RTL and testbench
====================================

// Module: spi_slave_word_rx
// PURPOSE
//  SPI responder (slave) for the 16-bit word streams our SPI masters emit (sample words to the MBED link).
//  Oversamples SCK/CSbar/MOSI on SYS_CLK and deserialises MSB-first words into a small FIFO with VALID/READY output.
//  Shifts a reply word out on MISO, latched from DATA_MISO at frame start.
//  Bench/loopback target for SPI_MASTER_UC and the receive front end for a board-to-board sample link.
// PARAMETERS
//  inBits      16  word length in bits per CSbar frame
//  FIFO_DEPTH   4  receive buffer depth in words (power of 2, >=2)
// PORTS
//  SYS_CLK    in   1       system clock (CLK_FAST domain, 70 MHz)
//  RSTbar     in   1       asynchronous active-low reset
//  ENA        in   1       accept new frames; sampled only at synced CSbar fall
//  SCK        in   1       SPI clock from master (async to SYS_CLK)
//  CSbar      in   1       SPI chip select, active low (async)
//  MOSI       in   1       SPI data from master (async)
//  MISO       out  1       SPI data to master
//  MISO_OE    out  1       MISO output enable (tri-state control at top level)
//  DATA_MISO  in   inBits  reply word, latched at frame start
//  DATA_OUT   out  inBits  head-of-FIFO received word
//  VALID      out  1       DATA_OUT holds a word (FIFO not empty)
//  READY      in   1       consumer pop; pop occurs when VALID & READY
//  FIN        out  1       1-cycle pulse when a complete word is pushed
//  FRAME_ERR  out  1       1-cycle pulse when CSbar rises mid-word
//  OVERFLOW   out  1       sticky: complete word dropped because FIFO full
//  OVF_CLR    in   1       synchronous clear of OVERFLOW
// BEHAVIOUR
//  Reset (RSTbar=0, async): all outputs 0, FIFO empty, bit count 0, state IDLE; MISO_OE=0.
//  Sync: SCK, CSbar, MOSI each through 2 flops; edges from 3rd-flop compare. SCK high/low >= 4 SYS_CLK cycles (max SCK ~8.75 MHz).
//  SPI mode 0: MOSI captured on synced SCK rise; MISO advances on synced SCK fall; MSB first.
//  FSM:
//   IDLE   : synced CSbar fall & ENA -> load DATA_MISO into tx shifter, bitcnt=0, go SHIFT.
//            CSbar fall with ENA=0 -> stay IDLE, frame ignored, MISO_OE stays 0.
//   SHIFT  : each SCK rise: rx shifter <= {rx[inBits-2:0],MOSI}, bitcnt+1.
//            When bitcnt reaches inBits: push word next cycle, go HOLD.
//            CSbar rise before inBits bits: discard partial word, FRAME_ERR pulse, go IDLE.
//   HOLD   : extra SCK edges ignored (no shift, no error). CSbar rise -> IDLE.
//  MISO = tx MSB while state != IDLE, else 0; MISO_OE = (state != IDLE).
//   After inBits falls, MISO shifts in 0.
//  Push: FIN pulses the same cycle the word enters the FIFO.
//   Latency: VALID/DATA_OUT update <= 5 SYS_CLK after final SCK rise at pin.
//  FIFO: first-word-fall-through; DATA_OUT = head, valid whenever VALID=1.
//   DATA_OUT is don't-care when VALID=0.
//   Pop only when VALID & READY; READY with VALID=0 is ignored.
//   Push when full and no pop same cycle -> word dropped, OVERFLOW set, FIN not pulsed.
//   Push and pop in same cycle when full -> both succeed, no overflow.
//   Push and pop in same cycle when empty -> not possible (FWFT push lands first).
//  OVERFLOW: set by drop, cleared by OVF_CLR; set wins if both same cycle.
//  Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  RSTbar asserted mid-frame: frame abandoned; after release, waits in IDLE for next CSbar fall.
//   A CSbar already low at release is not a frame start.
// TESTING
//  1 Reset: RSTbar=0 with random pins -> MISO_OE=0, VALID=0, FIN/FRAME_ERR/OVERFLOW=0.
//  2 Frame: master sends 16'hA5C3 at SCK=SYS_CLK/8, DATA_MISO=16'h1234 ->
//    DATA_OUT=A5C3, VALID=1, one FIN pulse; master receives 1234.
//  3 Partial: CSbar rises after 9 bits -> one FRAME_ERR pulse, VALID stays 0.
//    Next full frame 16'h0001 is received correctly.
//  4 Overflow: 5 frames (0x0001..0x0005) with READY=0, depth 4 -> VALID=1, OVERFLOW=1.
//    Pops return 1,2,3,4; word 5 is lost. OVF_CLR -> OVERFLOW=0.
//  5 Full + concurrent: FIFO full, READY=1 held while frame 0x00FF completes ->
//    no OVERFLOW; pop order preserves 0x00FF last.
//  6 ENA=0 at CSbar fall: frame 0xBEEF -> no FIN, MISO_OE=0.
//    ENA=1 for next frame 0xCAFE -> received.

Source files
------------

// File: rtl/spi_slave_word_rx.sv
// SPI mode-0 responder: oversampled SCK/CSbar/MOSI, MSB-first word deserialiser
// feeding a first-word-fall-through FIFO, with a reply word shifted out on MISO.
module spi_slave_word_rx #(
   parameter int inBits     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              SYS_CLK,
   input  logic              RSTbar,
   input  logic              ENA,
   input  logic              SCK,
   input  logic              CSbar,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   input  logic [inBits-1:0] DATA_MISO,
   output logic [inBits-1:0] DATA_OUT,
   output logic              VALID,
   input  logic              READY,
   output logic              FIN,
   output logic              FRAME_ERR,
   output logic              OVERFLOW,
   input  logic              OVF_CLR
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(inBits + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t            state, state_nx;
   logic [2:0]        sck_q, cs_q;
   logic [1:0]        mosi_q;
   logic              sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
   logic [inBits-1:0] tx_sh, rx_sh;
   logic [BW-1:0]     bit_cnt;
   logic              load_tx, shift_rx, done, frame_err_nx, push_req;
   logic [inBits-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              pop, full, push_ok, drop;

   // CSbar synchroniser resets low so a CSbar already low at release is not seen as a fall
   always_ff @(posedge SYS_CLK or negedge RSTbar) begin
      if (!RSTbar) begin
         sck_q  <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[1:0], SCK};
         cs_q   <= {cs_q[1:0], CSbar};
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign cs_fall  = ~cs_q[1] & cs_q[2];
   assign cs_rise  = cs_q[1] & ~cs_q[2];
   assign mosi_s   = mosi_q[1];

   always_ff @(posedge SYS_CLK or negedge RSTbar) begin
      if (!RSTbar) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      load_tx      = 1'b0;
      shift_rx     = 1'b0;
      done         = 1'b0;
      frame_err_nx = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall && ENA) begin
               load_tx  = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               frame_err_nx = 1'b1;
               state_nx     = IDLE;
            end else if (sck_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == BW'(inBits - 1)) begin
                  done     = 1'b1;
                  state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            if (cs_rise) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK or negedge RSTbar) begin
      if (!RSTbar) begin
         tx_sh     <= '0;
         rx_sh     <= '0;
         bit_cnt   <= '0;
         push_req  <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         if (load_tx) begin
            tx_sh   <= DATA_MISO;
            bit_cnt <= '0;
         end else begin
            if (state != IDLE && sck_fall) tx_sh <= {tx_sh[inBits-2:0], 1'b0};
            if (shift_rx) begin
               rx_sh   <= {rx_sh[inBits-2:0], mosi_s};
               bit_cnt <= bit_cnt + BW'(1);
            end
         end
         push_req  <= done;
         FRAME_ERR <= frame_err_nx;
      end
   end

   assign MISO_OE = (state != IDLE);
   assign MISO    = (state != IDLE) & tx_sh[inBits-1];

   assign VALID    = (count != '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop      = VALID & READY;
   assign push_ok  = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;
   assign DATA_OUT = mem[rd_ptr];

   always_ff @(posedge SYS_CLK or negedge RSTbar) begin
      if (!RSTbar) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         FIN      <= 1'b0;
         OVERFLOW <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= rx_sh;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         FIN <= push_ok;
         if (drop)         OVERFLOW <= 1'b1;
         else if (OVF_CLR) OVERFLOW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_slave_word_rx.sv
// Directed and randomized bench for spi_slave_word_rx, with a queue-based model of the receive FIFO.
module tb_spi_slave_word_rx;

   logic        SYS_CLK = 1'b0;
   logic        RSTbar, ENA, SCK, CSbar, MOSI, MISO, MISO_OE;
   logic [15:0] DATA_MISO, DATA_OUT;
   logic        VALID, READY, FIN, FRAME_ERR, OVERFLOW, OVF_CLR;

   int total = 0;
   int bad   = 0;
   int fin_cnt = 0;
   int ferr_cnt = 0;

   always #5 SYS_CLK = ~SYS_CLK;

   spi_slave_word_rx #(.inBits(16), .FIFO_DEPTH(4)) dut (
      .SYS_CLK(SYS_CLK), .RSTbar(RSTbar), .ENA(ENA), .SCK(SCK), .CSbar(CSbar),
      .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE), .DATA_MISO(DATA_MISO),
      .DATA_OUT(DATA_OUT), .VALID(VALID), .READY(READY), .FIN(FIN),
      .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR)
   );

   always @(negedge SYS_CLK) begin
      if (FIN === 1'b1)       fin_cnt++;
      if (FRAME_ERR === 1'b1) ferr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge SYS_CLK);
   endtask

   // SCK = SYS_CLK/8; optional one-cycle READY pulse in the last high phase
   task automatic spi_frame(input logic [15:0] word, input logic [15:0] reply, input int nbits,
                            input logic ena_v, input bit pop_at_end,
                            output logic [15:0] got, output logic oe_seen);
      logic [15:0] acc;
      acc       = '0;
      oe_seen   = 1'b0;
      DATA_MISO = reply;
      ENA       = ena_v;
      SCK       = 1'b0;
      MOSI      = word[15];
      CSbar     = 1'b0;
      repeat (6) begin @(negedge SYS_CLK); oe_seen |= MISO_OE; end
      for (int i = 0; i < nbits; i++) begin
         if (i < 16) acc = {acc[14:0], MISO};
         SCK = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (pop_at_end && i == nbits - 1 && k == 3) READY = 1'b1;
            @(negedge SYS_CLK);
            oe_seen |= MISO_OE;
         end
         READY = 1'b0;
         SCK   = 1'b0;
         MOSI  = (i + 1 < 16) ? word[14 - i] : 1'b0;
         repeat (4) begin @(negedge SYS_CLK); oe_seen |= MISO_OE; end
      end
      CSbar = 1'b1;
      repeat (8) begin @(negedge SYS_CLK); oe_seen |= MISO_OE; end
      got = acc;
   endtask

   task automatic pop_check(input string tag, input logic [15:0] exp);
      check({tag, ".valid"}, 32'(VALID), 32'd1);
      check({tag, ".data"}, 32'(DATA_OUT), 32'(exp));
      READY = 1'b1;
      tick(1);
      READY = 1'b0;
   endtask

   initial begin
      logic [15:0] got, w, r;
      logic        oe;
      logic [15:0] q[$];
      logic        ovf_exp;
      int          f0, e0, nbits, sel, npop;
      logic        ena_v;

      // 1: reset with random pins
      RSTbar = 1'b0;
      READY = 1'b0; OVF_CLR = 1'b0; ENA = 1'b1; SCK = 1'b0; CSbar = 1'b1; MOSI = 1'b0;
      DATA_MISO = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge SYS_CLK);
         SCK = 1'($urandom); CSbar = 1'($urandom); MOSI = 1'($urandom);
         ENA = 1'($urandom); READY = 1'($urandom); OVF_CLR = 1'($urandom);
         DATA_MISO = 16'($urandom);
      end
      tick(1);
      check("rst.miso_oe", 32'(MISO_OE), 32'd0);
      check("rst.miso", 32'(MISO), 32'd0);
      check("rst.valid", 32'(VALID), 32'd0);
      check("rst.fin", 32'(FIN), 32'd0);
      check("rst.frame_err", 32'(FRAME_ERR), 32'd0);
      check("rst.overflow", 32'(OVERFLOW), 32'd0);
      SCK = 1'b0; CSbar = 1'b1; MOSI = 1'b0; ENA = 1'b1; READY = 1'b0; OVF_CLR = 1'b0;
      tick(1);
      RSTbar = 1'b1;
      tick(6);

      // 2: basic frame
      f0 = fin_cnt;
      spi_frame(16'hA5C3, 16'h1234, 16, 1'b1, 1'b0, got, oe);
      check("f2.reply", 32'(got), 32'h1234);
      check("f2.fin", 32'(fin_cnt - f0), 32'd1);
      check("f2.oe", 32'(oe), 32'd1);
      pop_check("f2.pop", 16'hA5C3);
      check("f2.empty", 32'(VALID), 32'd0);

      // 3: partial frame then good frame
      e0 = ferr_cnt; f0 = fin_cnt;
      spi_frame(16'hFFFF, 16'h0, 9, 1'b1, 1'b0, got, oe);
      check("f3.ferr", 32'(ferr_cnt - e0), 32'd1);
      check("f3.nofin", 32'(fin_cnt - f0), 32'd0);
      check("f3.valid", 32'(VALID), 32'd0);
      spi_frame(16'h0001, 16'h0, 16, 1'b1, 1'b0, got, oe);
      pop_check("f3.pop", 16'h0001);

      // 4: overflow
      f0 = fin_cnt;
      for (int i = 1; i <= 5; i++) spi_frame(16'(i), 16'h0, 16, 1'b1, 1'b0, got, oe);
      check("f4.fin", 32'(fin_cnt - f0), 32'd4);
      check("f4.overflow", 32'(OVERFLOW), 32'd1);
      for (int i = 1; i <= 4; i++) pop_check("f4.pop", 16'(i));
      check("f4.empty", 32'(VALID), 32'd0);
      OVF_CLR = 1'b1; tick(1); OVF_CLR = 1'b0;
      check("f4.ovf_clr", 32'(OVERFLOW), 32'd0);

      // 5: full FIFO with pop coinciding with the push
      for (int i = 0; i < 4; i++) spi_frame(16'h0011 + 16'(i), 16'h0, 16, 1'b1, 1'b0, got, oe);
      f0 = fin_cnt;
      spi_frame(16'h00FF, 16'h0, 16, 1'b1, 1'b1, got, oe);
      check("f5.fin", 32'(fin_cnt - f0), 32'd1);
      check("f5.no_ovf", 32'(OVERFLOW), 32'd0);
      pop_check("f5.pop", 16'h0012);
      pop_check("f5.pop", 16'h0013);
      pop_check("f5.pop", 16'h0014);
      pop_check("f5.pop", 16'h00FF);
      check("f5.empty", 32'(VALID), 32'd0);

      // 6: ENA low at frame start
      f0 = fin_cnt;
      spi_frame(16'hBEEF, 16'h5555, 16, 1'b0, 1'b0, got, oe);
      check("f6.nofin", 32'(fin_cnt - f0), 32'd0);
      check("f6.oe", 32'(oe), 32'd0);
      check("f6.valid", 32'(VALID), 32'd0);
      spi_frame(16'hCAFE, 16'h0F0F, 16, 1'b1, 1'b0, got, oe);
      check("f6.reply", 32'(got), 32'h0F0F);
      pop_check("f6.pop", 16'hCAFE);

      // 7: reset mid-frame, CSbar still low at release
      e0 = ferr_cnt; f0 = fin_cnt;
      DATA_MISO = 16'hFFFF; ENA = 1'b1; CSbar = 1'b0; MOSI = 1'b1;
      tick(6);
      SCK = 1'b1; tick(4); SCK = 1'b0; tick(4);
      check("f7.oe_pre", 32'(MISO_OE), 32'd1);
      RSTbar = 1'b0; tick(2);
      check("f7.oe_rst", 32'(MISO_OE), 32'd0);
      RSTbar = 1'b1; tick(8);
      check("f7.oe_rel", 32'(MISO_OE), 32'd0);
      CSbar = 1'b1; tick(8);
      check("f7.ferr", 32'(ferr_cnt - e0), 32'd0);
      check("f7.fin", 32'(fin_cnt - f0), 32'd0);
      check("f7.valid", 32'(VALID), 32'd0);
      spi_frame(16'h3C5A, 16'hA0A0, 16, 1'b1, 1'b0, got, oe);
      check("f7.reply", 32'(got), 32'hA0A0);
      pop_check("f7.pop", 16'h3C5A);

      // 8: randomized frames against a queue model
      ovf_exp = 1'b0;
      for (int it = 0; it < 24; it++) begin
         w = 16'($urandom); r = 16'($urandom);
         sel = $urandom_range(0, 9);
         nbits = (sel == 0) ? 9 : (sel == 1) ? 18 : 16;
         ena_v = ($urandom_range(0, 7) != 0);
         f0 = fin_cnt; e0 = ferr_cnt;
         spi_frame(w, r, nbits, ena_v, 1'b0, got, oe);
         if (!ena_v) begin
            check("rnd.dis_oe", 32'(oe), 32'd0);
            check("rnd.dis_fin", 32'(fin_cnt - f0), 32'd0);
            check("rnd.dis_ferr", 32'(ferr_cnt - e0), 32'd0);
         end else if (nbits < 16) begin
            check("rnd.part_ferr", 32'(ferr_cnt - e0), 32'd1);
            check("rnd.part_fin", 32'(fin_cnt - f0), 32'd0);
         end else begin
            check("rnd.reply", 32'(got), 32'(r));
            check("rnd.ferr", 32'(ferr_cnt - e0), 32'd0);
            if (q.size() < 4) begin
               q.push_back(w);
               check("rnd.fin", 32'(fin_cnt - f0), 32'd1);
            end else begin
               ovf_exp = 1'b1;
               check("rnd.drop_fin", 32'(fin_cnt - f0), 32'd0);
            end
         end
         check("rnd.overflow", 32'(OVERFLOW), 32'(ovf_exp));
         check("rnd.valid", 32'(VALID), 32'(q.size() != 0));
         npop = $urandom_range(0, 2);
         for (int p = 0; p < npop; p++)
            if (q.size() > 0) pop_check("rnd.pop", q.pop_front());
         if ($urandom_range(0, 3) == 0) begin
            OVF_CLR = 1'b1; tick(1); OVF_CLR = 1'b0;
            ovf_exp = 1'b0;
         end
      end
      while (q.size() > 0) pop_check("rnd.drain", q.pop_front());
      check("rnd.empty", 32'(VALID), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      bad++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
